// File: rtl/dmem_pipe.sv
// Pipelined data memory for the core load/store port: byte-strobed writes,
// RD_LAT-deep read pipeline, out-of-range reads flagged through o_err.
module dmem_pipe #(
  parameter int DWIDTH    = 32,
  parameter int DEPTH     = 8192,
  parameter int RD_LAT    = 1,
  parameter     INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ren,
  input  logic                i_wen,
  input  logic [DWIDTH/8-1:0] i_wstrb,
  input  logic [31:0]         i_addr,
  input  logic [DWIDTH-1:0]   i_wdata,
  output logic                o_rvd,
  output logic [DWIDTH-1:0]   o_rdata,
  output logic                o_err,
  output logic                o_busy
);

  localparam int NB    = DWIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = (NB > 1) ? $clog2(NB) : 0;
  localparam int ABITS = IDX_W + OFF_W;

  if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_lat
    $error("dmem_pipe: RD_LAT must be in 1..8");
  end
  if ((DWIDTH % 8) != 0) begin : g_bad_width
    $error("dmem_pipe: DWIDTH must be a multiple of 8");
  end

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              oob;
  logic [DWIDTH-1:0] rd_word;

  assign idx     = i_addr[ABITS-1:OFF_W];
  assign oob     = (i_addr >> ABITS) != 32'd0;
  assign rd_word = oob ? '0 : mem[idx];

  // Array holds no reset; a write coincident with rst or out of range is dropped.
  always_ff @(posedge clk) begin
    if (!rst && i_wen && !oob) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wstrb[b]) mem[idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Read word is captured at the request edge, so later writes cannot alter it.
  // Non-valid stages carry zeros so the outputs never show stale data.
  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT-1:0] err_pipe;
  logic [DWIDTH-1:0] data_pipe [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) data_pipe[i] <= '0;
    end else begin
      vld_pipe[0]  <= i_ren;
      err_pipe[0]  <= i_ren & oob;
      data_pipe[0] <= i_ren ? rd_word : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        err_pipe[i]  <= err_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign o_rvd   = vld_pipe[RD_LAT-1];
  assign o_err   = err_pipe[RD_LAT-1];
  assign o_rdata = data_pipe[RD_LAT-1];
  assign o_busy  = |vld_pipe;

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench: three dmem_pipe instances (RD_LAT 1/3/4, DEPTH 1024) share
// one stimulus stream; vector table for single-cycle ops plus latency/reset runs.
module tb_dmem_pipe;

  logic        clk, rst, ren, wen;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;

  logic        rvd1, err1, busy1;
  logic [31:0] rdata1;
  logic        rvd3, err3, busy3;
  logic [31:0] rdata3;
  logic        rvd4, err4, busy4;
  logic [31:0] rdata4;

  dmem_pipe #(.DWIDTH(32), .DEPTH(1024), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .i_ren(ren), .i_wen(wen), .i_wstrb(wstrb),
    .i_addr(addr), .i_wdata(wdata),
    .o_rvd(rvd1), .o_rdata(rdata1), .o_err(err1), .o_busy(busy1));

  dmem_pipe #(.DWIDTH(32), .DEPTH(1024), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .i_ren(ren), .i_wen(wen), .i_wstrb(wstrb),
    .i_addr(addr), .i_wdata(wdata),
    .o_rvd(rvd3), .o_rdata(rdata3), .o_err(err3), .o_busy(busy3));

  dmem_pipe #(.DWIDTH(32), .DEPTH(1024), .RD_LAT(4)) u_lat4 (
    .clk(clk), .rst(rst), .i_ren(ren), .i_wen(wen), .i_wstrb(wstrb),
    .i_addr(addr), .i_wdata(wdata),
    .o_rvd(rvd4), .o_rdata(rdata4), .o_err(err4), .o_busy(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvd;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void add(logic r, logic w, logic [3:0] s, logic [31:0] a,
                              logic [31:0] d, logic xv, logic [31:0] xd, logic xe);
    vec_t v;
    v.ren = r; v.wen = w; v.wstrb = s; v.addr = a; v.wdata = d;
    v.rvd = xv; v.rdata = xd; v.err = xe;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, then look 1 time unit past the rising edge.
  task automatic step(logic r, logic w, logic [3:0] s, logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    ren = r; wen = w; wstrb = s; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          got;
    logic [31:0] got_data;

    rst = 1'b1; ren = 0; wen = 0; wstrb = 0; addr = 0; wdata = 0;

    // Expected outputs of each vector are for the lat1 DUT right after its edge.
    add(0, 1, 4'hF, 32'h10,   32'hDEADBEEF, 0, 32'h0,        0);
    add(1, 0, 4'h0, 32'h10,   32'h0,        1, 32'hDEADBEEF, 0);
    add(0, 1, 4'hF, 32'h20,   32'h11223344, 0, 32'h0,        0);
    add(0, 1, 4'h5, 32'h20,   32'hAABBCCDD, 0, 32'h0,        0);
    add(1, 0, 4'h0, 32'h20,   32'h0,        1, 32'h11BB33DD, 0);
    add(0, 1, 4'hF, 32'h30,   32'h5,        0, 32'h0,        0);
    add(1, 1, 4'hF, 32'h30,   32'h9,        1, 32'h5,        0);
    add(1, 0, 4'h0, 32'h30,   32'h0,        1, 32'h9,        0);
    add(0, 1, 4'hF, 32'h0,    32'h12345678, 0, 32'h0,        0);
    add(0, 1, 4'hF, 32'h1000, 32'hFFFFFFFF, 0, 32'h0,        0);
    add(1, 0, 4'h0, 32'h1000, 32'h0,        1, 32'h0,        1);
    add(1, 0, 4'h0, 32'h0,    32'h0,        1, 32'h12345678, 0);
    add(0, 1, 4'h0, 32'h20,   32'h0,        0, 32'h0,        0);
    add(1, 0, 4'h0, 32'h23,   32'h0,        1, 32'h11BB33DD, 0);
    add(0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0,        0);

    // Reset state.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("reset rvd1",  {31'b0, rvd1},  0);
    chk("reset busy1", {31'b0, busy1}, 0);
    chk("reset rdata1", rdata1, 0);
    chk("reset err1",  {31'b0, err1},  0);
    chk("reset busy3", {31'b0, busy3}, 0);
    chk("reset busy4", {31'b0, busy4}, 0);
    chk("reset rvd4",  {31'b0, rvd4},  0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].ren, vecs[i].wen, vecs[i].wstrb, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d rvd",   i), {31'b0, rvd1},  {31'b0, vecs[i].rvd});
      chk($sformatf("vec%0d rdata", i), rdata1,         vecs[i].rdata);
      chk($sformatf("vec%0d err",   i), {31'b0, err1},  {31'b0, vecs[i].err});
      chk($sformatf("vec%0d busy",  i), {31'b0, busy1}, {31'b0, vecs[i].rvd});
    end

    // Back-to-back reads through the 3-stage pipe.
    for (int k = 0; k < 4; k++) step(0, 1, 4'hF, 32'(4*k), 32'(k+1));
    for (int c = 0; c < 7; c++) begin
      if (c < 4) step(1, 0, 0, 32'(4*c), 0);
      else       step(0, 0, 0, 0, 0);
      chk($sformatf("b2b c%0d rvd3", c),  {31'b0, rvd3},  (c >= 2 && c <= 5) ? 1 : 0);
      chk($sformatf("b2b c%0d rdata3", c), rdata3,        (c >= 2 && c <= 5) ? 32'(c-1) : 0);
      chk($sformatf("b2b c%0d busy3", c), {31'b0, busy3}, (c <= 5) ? 1 : 0);
      chk($sformatf("b2b c%0d rdata1", c), rdata1,        (c < 4) ? 32'(c+1) : 0);
    end

    // Reset while two reads are in flight in the 4-stage pipe.
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h4, 0);
    step(0, 0, 0, 0, 0);
    chk("inflight rvd4",  {31'b0, rvd4},  0);
    chk("inflight busy4", {31'b0, busy4}, 1);
    rst = 1'b1;
    step(1, 1, 4'hF, 32'h4, 32'h00000BAD);
    chk("rst edge rvd4",  {31'b0, rvd4},  0);
    chk("rst edge busy4", {31'b0, busy4}, 0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("post rst c%0d rvd4", c),  {31'b0, rvd4},  0);
      chk($sformatf("post rst c%0d busy4", c), {31'b0, busy4}, 0);
    end

    // Memory survives reset and the write coincident with rst was ignored.
    step(1, 0, 0, 32'h4, 0);
    got = 0;
    got_data = 32'hX;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) step(0, 0, 0, 0, 0);
      if (rvd4 && got == 0) begin
        got = c;
        got_data = rdata4;
      end
    end
    chk("lat4 latency", 32'(got), 4);
    chk("lat4 rdata after rst", got_data, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
